// File: rtl/ysyx_22040127_div_pkg.sv
// Shared types and constants for the RV64M divide/remainder sequencer.
package ysyx_22040127_div_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned WLEN  = 32;
  localparam int unsigned CNT_W = 6;

  // Op-bit positions in the execute-stage R-type decode
  localparam int unsigned FUNCT3_REM_BIT  = 1;
  localparam int unsigned FUNCT3_UNS_BIT  = 0;
  localparam int unsigned OPCODE_WORD_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
    logic is_word;
  } div_req_t;

  // Latched operation context needed after the accept cycle
  typedef struct packed {
    logic is_rem;
    logic is_word;
    logic q_neg;
    logic r_neg;
  } div_op_t;

  function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] w);
    return {{(XLEN-WLEN){w[WLEN-1]}}, w};
  endfunction

  function automatic div_req_t decode_req(input logic [2:0] funct3, input logic [6:0] opcode);
    div_req_t r;
    r.is_signed = ~funct3[FUNCT3_UNS_BIT];
    r.is_rem    = funct3[FUNCT3_REM_BIT];
    r.is_word   = opcode[OPCODE_WORD_BIT];
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22040127_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
module ysyx_22040127_div_step
  import ysyx_22040127_div_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_msb_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;

  // The shifted value may exceed XLEN bits, but whenever it does the subtraction
  // happens and the true difference fits back into XLEN bits.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    q_bit_o = (shifted >= {1'b0, dvs_i});
    rem_o   = q_bit_o ? (shifted[XLEN-1:0] - dvs_i) : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/ysyx_22040127_div_seq.sv
// Multi-cycle RV64M divide/remainder sequencer: radix-2 restoring divider with
// fast paths for divide-by-zero and signed overflow.
module ysyx_22040127_div_seq
  import ysyx_22040127_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             out_valid_q, out_valid_d;
  div_op_t          op_q, op_d;

  logic             accept_c;
  logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, min_val, fast_res;
  logic             a_neg, b_neg, div_zero, sgn_ovf;
  logic [XLEN-1:0]  step_rem;
  logic             step_q_bit;
  logic [XLEN-1:0]  q_raw, q_fix, r_fix, sel_res, final_res;

  assign accept_c  = (state_q == IDLE) & in_valid & ~flush & ~rst;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE) | accept_c;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Operand preparation at the operating width, plus fast-path detection
  always_comb begin
    a_ext = src1;
    b_ext = src2;
    if (is_word) begin
      a_ext = is_signed ? sext_word(src1[WLEN-1:0]) : XLEN'(src1[WLEN-1:0]);
      b_ext = is_signed ? sext_word(src2[WLEN-1:0]) : XLEN'(src2[WLEN-1:0]);
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? (~a_ext + XLEN'(1)) : a_ext;
    b_mag    = b_neg ? (~b_ext + XLEN'(1)) : b_ext;
    min_val  = is_word ? sext_word({1'b1, {(WLEN-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    sgn_ovf  = is_signed & (a_ext == min_val) & (b_ext == '1);
    if (div_zero) begin
      fast_res = is_rem ? (is_word ? sext_word(src1[WLEN-1:0]) : src1) : '1;
    end else begin
      fast_res = is_rem ? '0 : a_ext;
    end
  end

  ysyx_22040127_div_step u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[XLEN-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // Sign correction and word sign-extension of the final iteration's result
  always_comb begin
    q_raw     = {dvd_q[XLEN-2:0], step_q_bit};
    q_fix     = op_q.q_neg ? (~q_raw + XLEN'(1)) : q_raw;
    r_fix     = op_q.r_neg ? (~step_rem + XLEN'(1)) : step_rem;
    sel_res   = op_q.is_rem ? r_fix : q_fix;
    final_res = op_q.is_word ? sext_word(sel_res[WLEN-1:0]) : sel_res;
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    op_d        = op_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          op_d.is_rem  = is_rem;
          op_d.is_word = is_word;
          op_d.q_neg   = a_neg ^ b_neg;
          op_d.r_neg   = a_neg;
          if (div_zero || sgn_ovf) begin
            result_d    = fast_res;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            // Word dividends start left-aligned so 32 shifts consume them exactly
            dvd_d   = is_word ? {a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            cnt_d   = is_word ? CNT_W'(WLEN-1) : CNT_W'(XLEN-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = q_raw;
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d       = '0;
          result_d    = final_res;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      op_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      op_q        <= op_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_div_seq.sv
// Bench for the divide/remainder sequencer: cycle-level reference model plus
// directed operations with hand-computed results and latencies.
module tb_ysyx_22040127_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic        is_rem = 1'b0;
  logic        is_word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_acc = 0;
  bit chk_en = 0;

  // Reference model state
  bit          m_busy = 0;
  bit          m_valid = 0;
  int          m_wait = 0;
  logic [63:0] m_res = '0;

  ysyx_22040127_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .is_rem    (is_rem),
    .is_word   (is_word),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit s, input bit r, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, m32;
    logic [63:0] q64, m64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; m32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; m32 = 32'd0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        m32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        m32 = a32 % b32;
      end
      return r ? {{32{m32[31]}}, m32} : {{32{q32[31]}}, q32};
    end
    if (b == 64'd0) begin
      q64 = '1; m64 = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; m64 = 64'd0;
    end else if (s) begin
      q64 = $signed(a) / $signed(b);
      m64 = $signed(a) % $signed(b);
    end else begin
      q64 = a / b;
      m64 = a % b;
    end
    return r ? m64 : q64;
  endfunction

  // Cycles from accept to first out_valid
  function automatic int ref_lat(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
    bit fast;
    if (w) fast = (b[31:0] == 32'd0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   fast = (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
    return fast ? 1 : (w ? 33 : 65);
  endfunction

  // Model advances on each clock edge from the sampled inputs
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_wait = 0;
    end else if (flush) begin
      m_busy = 0; m_valid = 0; m_wait = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 0; m_busy = 0;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1;
    end else if (!m_busy && in_valid) begin
      m_busy = 1;
      m_res  = ref_div(is_signed, is_rem, is_word, src1, src2);
      if (ref_lat(is_signed, is_word, src1, src2) == 1) m_valid = 1;
      else m_wait = ref_lat(is_signed, is_word, src1, src2) - 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(!m_busy));
      check("busy", 64'(busy), 64'(m_busy | (in_valid & !flush & !rst & !m_busy)));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) check("result", result, m_res);
    end
  end

  task automatic issue(input bit s, input bit r, input bit w, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; is_signed = s; is_rem = r; is_word = w; src1 = a; src2 = b;
    @(negedge clk);
    t_acc = cyc;
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
    is_signed = 1'($urandom); is_rem = 1'($urandom); is_word = 1'($urandom);
  endtask

  task automatic run_op(input string nm, input bit s, input bit r, input bit w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat, input int hold);
    int n;
    bit seen;
    issue(s, r, w, a, b);
    seen = 0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = (out_valid === 1'b1);
    end
    check({nm, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({nm, "_lat"}, 64'(cyc - t_acc), 64'(lat));
      check({nm, "_res"}, result, exp);
      repeat (hold) begin
        @(negedge clk);
        check({nm, "_hold_res"}, result, exp);
        check({nm, "_hold_busy"}, 64'(busy), 64'd1);
        check({nm, "_hold_ready"}, 64'(in_ready), 64'd0);
      end
      #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      check({nm, "_ready_after"}, 64'(in_ready), 64'd1);
      check({nm, "_valid_after"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    bit any;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    run_op("divu",   0, 0, 0, 64'd100, 64'd7, 64'd14, 65, 0);
    run_op("remu",   0, 1, 0, 64'd100, 64'd7, 64'd2, 65, 0);
    run_op("rem_n",  1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("div_n",  1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("div_z",  1, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remw_z", 1, 1, 1, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("div_ov", 1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ov", 1, 1, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("divuw",  0, 0, 1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    run_op("divw_n", 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0);
    run_op("remw_n", 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    run_op("remuw",  0, 1, 1, 64'hDEAD_0000_8000_0005, 64'h10, 64'd5, 33, 0);
    run_op("divw_ov",1, 0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("remuw_z",0, 1, 1, 64'h8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1, 0);
    run_op("divu_bp",0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65, 5);

    // Flush during the 10th CALC cycle with a competing request
    issue(0, 0, 0, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1; src2 = 64'd0;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_busy", 64'(busy), 64'd0);
    any = 0;
    repeat (80) begin @(negedge clk); if (out_valid !== 1'b0) any = 1; end
    check("flush_no_valid", 64'(any), 64'd0);

    // Same with reset
    issue(0, 0, 0, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_result", result, 64'd0);
    check("rst2_busy", 64'(busy), 64'd0);
    any = 0;
    repeat (80) begin @(negedge clk); if (out_valid !== 1'b0) any = 1; end
    check("rst2_no_valid", 64'(any), 64'd0);

    // Flush with in_valid while idle: not accepted
    @(posedge clk); #1 flush = 1'b1; in_valid = 1'b1; src1 = 64'd9; src2 = 64'd0;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle_flush_ready", 64'(in_ready), 64'd1);
    check("idle_flush_valid", 64'(out_valid), 64'd0);

    // Flush coinciding with the DONE handshake
    issue(1, 0, 0, 64'd5, 64'd0);
    @(negedge clk);
    check("hs_flush_pre", 64'(out_valid), 64'd1);
    #1 out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("hs_flush_ready", 64'(in_ready), 64'd1);
    check("hs_flush_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("hs_flush_nodup", 64'(out_valid), 64'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
